// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register for the 5-stage MIPS pipeline.
// Captures the fetched instruction and PC+4, detects load-use hazards against
// ID/EX (stalling IF and ID for one cycle), squashes the fetched instruction
// on a taken branch/jump resolved in ID, and keeps saturating stall/flush
// event counters for performance debug.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   instruction_in  fetched instruction from IF
//   pc4_in          PC+4 from IF
//   and_z_b         taken-branch select from ID control
//   Jmp             jump select from ID control (0 = sequential)
//   id_ex_mem_read  instruction in EX is a load
//   id_ex_rt        destination register of that load
//   instruction_out registered instruction to ID
//   pc4_out         registered PC+4 to ID
//   valid_out       1 = real instruction, 0 = bubble
//   pc_write        PC write enable to IF (0 = hold PC)
//   stall_out       1 = ID must zero its control signals
//   stall_count     saturating count of hazard cycles
//   flush_count     saturating count of flushes
module if_id_pipe_reg #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction_in,
  input  logic [31:0]      pc4_in,
  input  logic             and_z_b,
  input  logic [1:0]       Jmp,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  output logic [31:0]      instruction_out,
  output logic [31:0]      pc4_out,
  output logic             valid_out,
  output logic             pc_write,
  output logic             stall_out,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rt;
  logic       hazard;
  logic       flush;

  assign op = instruction_out[31:26];
  assign rs = instruction_out[25:21];
  assign rt = instruction_out[20:16];

  // R-type, beq, bne and sw read rt as a source operand.
  always_comb begin
    uses_rt = 1'b0;
    case (op)
      6'h00, 6'h04, 6'h05, 6'h2B: uses_rt = 1'b1;
      default:                    uses_rt = 1'b0;
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    flush  = 1'b0;
    if (valid_out && id_ex_mem_read && (id_ex_rt != 5'd0) &&
        ((id_ex_rt == rs) || (uses_rt && (id_ex_rt == rt))))
      hazard = 1'b1;
    // A stalled instruction's branch/jump decision uses stale operands.
    if (!hazard && (and_z_b || (Jmp != 2'b00)))
      flush = 1'b1;
  end

  assign stall_out = hazard;
  assign pc_write  = ~hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction_out <= NOP_INST;
      pc4_out         <= '0;
      valid_out       <= 1'b0;
    end else if (hazard) begin
      instruction_out <= instruction_out;
      pc4_out         <= pc4_out;
      valid_out       <= valid_out;
    end else if (flush) begin
      instruction_out <= NOP_INST;
      pc4_out         <= pc4_in;
      valid_out       <= 1'b0;
    end else begin
      instruction_out <= instruction_in;
      pc4_out         <= pc4_in;
      valid_out       <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (hazard && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (flush && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule
